peridot_phy_rxd_sampler: RTL

UART receiver PHY for the PERIDOT host bridge: the receive-side counterpart of the UART sender PHY, on the same byte-stream fabric. Recovers 8N1 frames from the asynchronous `rxd` line using a clock-divider bit timer with mid-bit sampling. Emits each byte on an Avalon-ST source with a framing-error flag, and reports overruns when the consumer stalls.

---
 rtl/peridot_phy_rxd_sampler_if.sv | 36 +++
 rtl/peridot_phy_rxd_sampler.sv | 125 ++++++++++++
 2 files changed

// File: rtl/peridot_phy_rxd_sampler_if.sv
// ============================================================================
// Module   : peridot_phy_rxd_sampler_if
// Brief    : Serial line input and Avalon-ST byte source of the UART RX PHY.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface peridot_phy_rxd_sampler_if;
  logic       rxd;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_error;
  logic       overrun;

  // master is the receiver PHY (byte source); slave is the line driver / consumer
  modport master (
    input  rxd,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_error,
    output overrun
  );

  modport slave (
    output rxd,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_error,
    input  overrun
  );
endinterface

`default_nettype wire

// File: rtl/peridot_phy_rxd_sampler.sv
// ============================================================================
// Module   : peridot_phy_rxd_sampler
// Brief    : 8N1 UART receiver PHY, mid-bit sampling, Avalon-ST byte output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module peridot_phy_rxd_sampler #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int UART_BAUDRATE   = 115200
) (
  input  wire logic                      clk,
  input  wire logic                      reset_n,
  peridot_phy_rxd_sampler_if.master      bus
);

  localparam int          c_div_full     = CLOCK_FREQUENCY / UART_BAUDRATE - 1;
  localparam logic [11:0] c_clock_divnum = c_div_full[11:0];
  localparam logic [11:0] c_half_divnum  = c_clock_divnum >> 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_sync1;
  logic        r_rxd_s;
  logic        r_rxd_d;
  logic [11:0] r_divcount;
  logic [2:0]  r_bitcount;
  logic [7:0]  r_shift;
  logic        r_out_valid;
  logic [7:0]  r_out_data;
  logic        r_out_error;
  logic        r_overrun;

  logic        w_tick;
  logic        w_load;

  assign w_tick = (r_divcount == 12'd0);
  assign w_load = (r_state == ST_STOP) && w_tick;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_sync1     <= 1'b1;
      r_rxd_s     <= 1'b1;
      r_rxd_d     <= 1'b1;
      r_divcount  <= 12'd0;
      r_bitcount  <= 3'd0;
      r_shift     <= 8'h00;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_out_error <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_sync1 <= bus.rxd;
      r_rxd_s <= r_sync1;
      r_rxd_d <= r_rxd_s;

      if ((r_state != ST_IDLE) && !w_tick) begin
        r_divcount <= r_divcount - 12'd1;
      end

      case (r_state)
        ST_IDLE: begin
          // only a high-to-low transition starts a frame, so a held break is ignored
          if (r_rxd_d && !r_rxd_s) begin
            r_divcount <= c_half_divnum;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          if (w_tick) begin
            if (!r_rxd_s) begin
              r_divcount <= c_clock_divnum;
              r_bitcount <= 3'd0;
              r_state    <= ST_DATA;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_shift    <= {r_rxd_s, r_shift[7:1]};
            r_divcount <= c_clock_divnum;
            if (r_bitcount == 3'd7) begin
              r_state <= ST_STOP;
            end else begin
              r_bitcount <= r_bitcount + 3'd1;
            end
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // a load coinciding with a transfer replaces the delivered byte without overrun
      r_overrun <= w_load && r_out_valid && !bus.out_ready;
      if (w_load) begin
        r_out_data  <= r_shift;
        r_out_error <= ~r_rxd_s;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_error = r_out_error;
  assign bus.overrun   = r_overrun;

endmodule

`default_nettype wire
